// File: rtl/bus_cycle_control.sv
// Bus cycle sequencer: per-class wait states, DSACK sized to port width, external-ready
// handshake for slot/Ethernet devices, timeout/unmapped BERR and the sticky vector_fetched flag.
module bus_cycle_control #(
  parameter int WAIT_ROM      = 3,
  parameter int WAIT_WORD     = 1,
  parameter int WAIT_BYTE     = 4,
  parameter int WAIT_LONG     = 0,
  parameter int TIMEOUT       = 255,
  parameter int VECTOR_CYCLES = 4,
  parameter int DEV_W         = 4,
  parameter int PW_W          = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             as,
  input  logic             function_normal,
  input  logic [DEV_W-1:0] device_selected,
  input  logic [PW_W-1:0]  port_width,
  input  logic             ext_ack,
  output logic [1:0]       dsack,
  output logic             berr,
  output logic             device_strobe,
  output logic             vector_fetched
);

  localparam logic [DEV_W-1:0] DEVICE_NULL       = 4'd0;
  localparam logic [DEV_W-1:0] DEVICE_ROM        = 4'd1;
  localparam logic [DEV_W-1:0] DEVICE_RAM        = 4'd2;
  localparam logic [DEV_W-1:0] DEVICE_REGISTER8  = 4'd3;
  localparam logic [DEV_W-1:0] DEVICE_REGISTER32 = 4'd4;
  localparam logic [DEV_W-1:0] DEVICE_QUART      = 4'd5;
  localparam logic [DEV_W-1:0] DEVICE_SLOT0      = 4'd6;
  localparam logic [DEV_W-1:0] DEVICE_SLOT1      = 4'd7;
  localparam logic [DEV_W-1:0] DEVICE_SLOT2      = 4'd8;
  localparam logic [DEV_W-1:0] DEVICE_SLOT3      = 4'd9;
  localparam logic [DEV_W-1:0] DEVICE_ETH        = 4'd10;

  localparam logic [PW_W-1:0] PORT_WIDTH_NULL = 2'b00;
  localparam logic [PW_W-1:0] PORT_WIDTH_BYTE = 2'b01;
  localparam logic [PW_W-1:0] PORT_WIDTH_WORD = 2'b10;
  localparam logic [PW_W-1:0] PORT_WIDTH_LONG = 2'b11;

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [2:0] VEC_DONE = 3'(VECTOR_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ACK  = 2'b10,
    ST_BERR = 2'b11
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  wait_cnt_r, wait_cnt_s;
  logic [7:0]  to_cnt_r, to_cnt_s;
  logic [2:0]  vec_cnt_r, vec_cnt_s;
  logic        vf_r, vf_s;
  logic [1:0]  dsack_r, dsack_s;
  logic        berr_r, berr_s;
  logic        strobe_r, strobe_s;
  logic        ext_dev_s;
  logic        ack_ready_s;

  // ROM (including boot-mapped ROM) has its own wait class regardless of port width
  function automatic logic [3:0] wait_load(input logic [DEV_W-1:0] dev,
                                           input logic [PW_W-1:0] pw);
    logic [3:0] w;
    if (dev == DEVICE_ROM) begin
      w = 4'(WAIT_ROM);
    end else begin
      case (pw)
        PORT_WIDTH_BYTE: w = 4'(WAIT_BYTE);
        PORT_WIDTH_WORD: w = 4'(WAIT_WORD);
        PORT_WIDTH_LONG: w = 4'(WAIT_LONG);
        default:         w = 4'd0;
      endcase
    end
    return w;
  endfunction

  function automatic logic [1:0] dsack_encode(input logic [PW_W-1:0] pw);
    logic [1:0] d;
    case (pw)
      PORT_WIDTH_BYTE: d = 2'b01;
      PORT_WIDTH_WORD: d = 2'b10;
      PORT_WIDTH_LONG: d = 2'b11;
      default:         d = 2'b00;
    endcase
    return d;
  endfunction

  // Completion qualifier: wait states spent, external ready for slot/Ethernet, mapped port
  always_comb begin
    ext_dev_s = 1'b0;
    case (device_selected)
      DEVICE_SLOT0, DEVICE_SLOT1, DEVICE_SLOT2, DEVICE_SLOT3, DEVICE_ETH: ext_dev_s = 1'b1;
      default: ext_dev_s = 1'b0;
    endcase
    ack_ready_s = (wait_cnt_r == 4'd0) && (!ext_dev_s || ext_ack) &&
                  (port_width != PORT_WIDTH_NULL);
  end

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_s    = state_r;
    wait_cnt_s = wait_cnt_r;
    to_cnt_s   = to_cnt_r;
    vec_cnt_s  = vec_cnt_r;
    vf_s       = vf_r;
    dsack_s    = 2'b00;
    berr_s     = 1'b0;
    strobe_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (as && function_normal) begin
          state_s    = ST_WAIT;
          wait_cnt_s = wait_load(device_selected, port_width);
          to_cnt_s   = 8'd0;
          strobe_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        wait_cnt_s = (wait_cnt_r == 4'd0) ? 4'd0 : (wait_cnt_r - 4'd1);
        to_cnt_s   = to_cnt_r + 8'd1;
        if (!as) begin
          state_s = ST_IDLE;
        end else if (ack_ready_s) begin
          // ACK has priority over a timeout falling due on the same edge
          state_s  = ST_ACK;
          dsack_s  = dsack_encode(port_width);
          strobe_s = 1'b1;
        end else if (to_cnt_r == TO_LAST) begin
          state_s = ST_BERR;
          berr_s  = 1'b1;
        end else begin
          state_s  = ST_WAIT;
          strobe_s = 1'b1;
        end
      end
      ST_ACK: begin
        if (!as) begin
          state_s = ST_IDLE;
          if (!vf_r) begin
            vec_cnt_s = vec_cnt_r + 3'd1;
            vf_s      = (vec_cnt_s == VEC_DONE);
          end else begin
            vec_cnt_s = vec_cnt_r;
          end
        end else begin
          state_s  = ST_ACK;
          dsack_s  = dsack_r;
          strobe_s = 1'b1;
        end
      end
      ST_BERR: begin
        if (!as) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BERR;
          berr_s  = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      wait_cnt_r <= 4'd0;
      to_cnt_r   <= 8'd0;
      vec_cnt_r  <= 3'd0;
      vf_r       <= 1'b0;
      dsack_r    <= 2'b00;
      berr_r     <= 1'b0;
      strobe_r   <= 1'b0;
    end else begin
      state_r    <= state_s;
      wait_cnt_r <= wait_cnt_s;
      to_cnt_r   <= to_cnt_s;
      vec_cnt_r  <= vec_cnt_s;
      vf_r       <= vf_s;
      dsack_r    <= dsack_s;
      berr_r     <= berr_s;
      strobe_r   <= strobe_s;
    end
  end

  assign dsack          = dsack_r;
  assign berr           = berr_r;
  assign device_strobe  = strobe_r;
  assign vector_fetched = vf_r;

endmodule

// File: tb/tb_bus_cycle_control.sv
// Directed bench for bus_cycle_control: expected responses are queued at cycle start and
// compared (value and latency from E0) when dsack or berr appears.
module tb_bus_cycle_control;

  localparam logic [3:0] DEV_NULL  = 4'd0;
  localparam logic [3:0] DEV_ROM   = 4'd1;
  localparam logic [3:0] DEV_RAM   = 4'd2;
  localparam logic [3:0] DEV_REG8  = 4'd3;
  localparam logic [3:0] DEV_REG32 = 4'd4;
  localparam logic [3:0] DEV_QUART = 4'd5;
  localparam logic [3:0] DEV_SLOT0 = 4'd6;
  localparam logic [3:0] DEV_SLOT1 = 4'd7;
  localparam logic [3:0] DEV_ETH   = 4'd10;
  localparam logic [1:0] PW_NULL   = 2'b00;
  localparam logic [1:0] PW_BYTE   = 2'b01;
  localparam logic [1:0] PW_WORD   = 2'b10;
  localparam logic [1:0] PW_LONG   = 2'b11;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       as;
  logic       function_normal;
  logic [3:0] device_selected;
  logic [1:0] port_width;
  logic       ext_ack;
  logic [1:0] dsack;
  logic       berr;
  logic       device_strobe;
  logic       vector_fetched;

  typedef struct {
    logic [1:0] dsack;
    logic       berr;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   e0 = 0;

  bus_cycle_control dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .as              (as),
    .function_normal (function_normal),
    .device_selected (device_selected),
    .port_width      (port_width),
    .ext_ack         (ext_ack),
    .dsack           (dsack),
    .berr            (berr),
    .device_strobe   (device_strobe),
    .vector_fetched  (vector_fetched)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_cycle(input logic [3:0] dev, input logic [1:0] pw);
    as              = 1'b1;
    function_normal = 1'b1;
    device_selected = dev;
    port_width      = pw;
    e0              = cyc + 1;
  endtask

  task automatic expect_resp(input logic [1:0] d, input logic b, input int lat);
    exp_t e;
    e.dsack = d;
    e.berr  = b;
    e.lat   = lat;
    sb.push_back(e);
  endtask

  task automatic wait_resp(input string tag, input int limit);
    exp_t e;
    bit   got;
    int   lat;
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (dsack !== 2'b00 || berr !== 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    lat = cyc - e0;
    check({tag, "_resp_seen"}, 32'(got), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_dsack"}, 32'(dsack), 32'(e.dsack));
      check({tag, "_berr"}, 32'(berr), 32'(e.berr));
      check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    end
  endtask

  task automatic end_cycle(input string tag);
    as      = 1'b0;
    ext_ack = 1'b0;
    tick();
    check({tag, "_idle_dsack"}, 32'(dsack), 32'd0);
    check({tag, "_idle_berr"}, 32'(berr), 32'd0);
    check({tag, "_idle_strobe"}, 32'(device_strobe), 32'd0);
  endtask

  task automatic do_cycle(input string tag, input logic [3:0] dev, input logic [1:0] pw,
                          input logic [1:0] d, input logic b, input int lat);
    start_cycle(dev, pw);
    expect_resp(d, b, lat);
    wait_resp(tag, lat + 10);
    end_cycle(tag);
  endtask

  task automatic reset_pulse();
    #2 reset_n = 1'b0;
    #1;
    check("rst_dsack", 32'(dsack), 32'd0);
    check("rst_berr", 32'(berr), 32'd0);
    check("rst_strobe", 32'(device_strobe), 32'd0);
    check("rst_vf", 32'(vector_fetched), 32'd0);
    as      = 1'b0;
    ext_ack = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int bad;
    reset_n         = 1'b0;
    as              = 1'b0;
    function_normal = 1'b0;
    device_selected = DEV_NULL;
    port_width      = PW_NULL;
    ext_ack         = 1'b0;
    tick();
    tick();
    check("por_dsack", 32'(dsack), 32'd0);
    check("por_strobe", 32'(device_strobe), 32'd0);
    check("por_vf", 32'(vector_fetched), 32'd0);
    reset_n = 1'b1;
    tick();

    // Reset asserted mid-WAIT
    start_cycle(DEV_ROM, PW_WORD);
    tick();
    tick();
    check("wait_strobe", 32'(device_strobe), 32'd1);
    reset_pulse();

    // Boot vector fetch: four ROM word cycles
    for (int n = 0; n < 4; n++) begin
      do_cycle($sformatf("rom%0d", n), DEV_ROM, PW_WORD, 2'b10, 1'b0, 4);
      check($sformatf("rom%0d_vf", n), 32'(vector_fetched), (n == 3) ? 32'd1 : 32'd0);
    end

    do_cycle("quart", DEV_QUART, PW_BYTE, 2'b01, 1'b0, 5);
    do_cycle("reg32", DEV_REG32, PW_LONG, 2'b11, 1'b0, 1);
    do_cycle("reg8", DEV_REG8, PW_BYTE, 2'b01, 1'b0, 5);
    do_cycle("ram", DEV_RAM, PW_WORD, 2'b10, 1'b0, 2);

    // Non-normal function code is not owned here
    as              = 1'b1;
    function_normal = 1'b0;
    device_selected = DEV_ROM;
    port_width      = PW_WORD;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (device_strobe !== 1'b0 || dsack !== 2'b00) bad++;
    end
    check("fn_ignored", 32'(bad), 32'd0);
    as = 1'b0;
    tick();

    // SLOT1 waits on ext_ack for 20 clocks
    start_cycle(DEV_SLOT1, PW_WORD);
    expect_resp(2'b10, 1'b0, 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dsack !== 2'b00 || berr !== 1'b0) bad++;
    end
    check("slot1_hold", 32'(bad), 32'd0);
    ext_ack = 1'b1;
    wait_resp("slot1", 5);
    end_cycle("slot1");

    ext_ack = 1'b1;
    do_cycle("eth", DEV_ETH, PW_WORD, 2'b10, 1'b0, 2);

    // Unmapped access times out
    do_cycle("null", DEV_NULL, PW_NULL, 2'b00, 1'b1, 255);

    // SLOT0 ready arrives on the timeout edge: ACK wins
    start_cycle(DEV_SLOT0, PW_WORD);
    expect_resp(2'b10, 1'b0, 255);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (dsack !== 2'b00 || berr !== 1'b0) bad++;
    end
    check("slot0_hold", 32'(bad), 32'd0);
    ext_ack = 1'b1;
    wait_resp("slot0", 5);
    end_cycle("slot0");
    check("vf_sticky", 32'(vector_fetched), 32'd1);

    // Reset while in ACK clears dsack and the vector flag
    start_cycle(DEV_REG32, PW_LONG);
    expect_resp(2'b11, 1'b0, 1);
    wait_resp("reg32_pre_rst", 5);
    reset_pulse();

    // Aborted and BERR cycles do not count toward vector fetch
    for (int n = 0; n < 3; n++) begin
      do_cycle($sformatf("rom_b%0d", n), DEV_ROM, PW_WORD, 2'b10, 1'b0, 4);
    end
    start_cycle(DEV_ROM, PW_WORD);
    tick();
    tick();
    end_cycle("abort");
    do_cycle("null_b", DEV_NULL, PW_NULL, 2'b00, 1'b1, 255);
    check("vf_after_abort_berr", 32'(vector_fetched), 32'd0);
    do_cycle("rom_b3", DEV_ROM, PW_WORD, 2'b10, 1'b0, 4);
    check("vf_after_4th", 32'(vector_fetched), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
